// File: rtl/apb_irq_pkg.sv
// Shared register map and sizing helpers for apb_irq_controller_n.
package apb_irq_pkg;

    localparam logic [31:0] REG_MODE      = 32'd0;
    localparam logic [31:0] REG_ID        = 32'd1;
    localparam logic [31:0] REG_STATUS    = 32'd2;
    localparam logic [31:0] REG_MASK      = 32'd3;
    localparam logic [31:0] REG_THR       = 32'd4;
    localparam logic [31:0] REG_PRIO_BASE = 32'd5;

    localparam int ID_VALID_BIT = 31;

    // A single channel still needs a one-bit ID port.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_arbiter.sv
// Combinational priority arbiter: highest priority wins, ties go to the lowest index.
module irq_prio_arbiter
    import apb_irq_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    parameter  int PRIO_W  = 3,
    localparam int ID_W    = id_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0]        cand,
    input  logic [NUM_IRQ*PRIO_W-1:0] prio,
    output logic                      vld,
    output logic [ID_W-1:0]           id
);
    localparam int LEAVES = 1 << ID_W;
    localparam int NODES  = 2 * LEAVES - 1;

    logic [NODES-1:0]             nv;
    logic [NODES-1:0][PRIO_W-1:0] np;
    logic [NODES-1:0][ID_W-1:0]   ni;

    // Heap-ordered tree; the left child always holds the lower indices, so
    // the right child only wins on a strictly higher priority.
    always_comb begin
        nv = '0;
        np = '0;
        ni = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            nv[LEAVES-1+i] = cand[i];
            np[LEAVES-1+i] = prio[i*PRIO_W +: PRIO_W];
            ni[LEAVES-1+i] = ID_W'(i);
        end
        for (int j = LEAVES - 2; j >= 0; j--) begin
            if (nv[2*j+2] && (!nv[2*j+1] || (np[2*j+2] > np[2*j+1]))) begin
                nv[j] = 1'b1;
                np[j] = np[2*j+2];
                ni[j] = ni[2*j+2];
            end else begin
                nv[j] = nv[2*j+1];
                np[j] = np[2*j+1];
                ni[j] = ni[2*j+1];
            end
        end
    end

    assign vld = nv[0];
    assign id  = ni[0];

endmodule

// File: rtl/apb_irq_controller_n.sv
// APB interrupt controller with per-channel pending/mask/priority and a registered arbiter.
// Define IRQ_LEVEL_MODE_EN to build the MODE register and the level-sensitive request path.
module apb_irq_controller_n
    import apb_irq_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    parameter  int PRIO_W  = 3,
    localparam int ID_W    = id_width(NUM_IRQ)
) (
    input  logic               pclk_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [31:0]        paddr_i,
    input  logic [31:0]        pwdata_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic [NUM_IRQ-1:0] irq_trigger_i,
    output logic               interrupt_o,
    output logic [ID_W-1:0]    irq_id_o
);
    logic                           access, wr, mapped, win_vld, unused_wdata;
    logic [NUM_IRQ-1:0]             mode, mask, pending, prev, cand, ack, clr, rise, prio_hit;
    logic [NUM_IRQ-1:0][PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]              thr;
    logic [ID_W-1:0]                win_id;
    logic [31:0]                    rdata;

    assign access       = psel_i & penable_i;
    assign wr           = access & pwrite_i;
    assign pready_o     = 1'b1;
    assign unused_wdata = ^pwdata_i;

    always_comb begin
        prio_hit = '0;
        ack      = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            prio_hit[k] = (paddr_i == REG_PRIO_BASE + 32'(k));
            ack[k]      = (pwdata_i[ID_W-1:0] == ID_W'(k));
        end
    end

    assign mapped = (paddr_i <= REG_THR) || (|prio_hit);

`ifdef IRQ_LEVEL_MODE_EN
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i)                      mode <= '0;
        else if (wr && paddr_i == REG_MODE) mode <= pwdata_i[NUM_IRQ-1:0];
    end
`else
    assign mode = '0;
`endif

    // Clears and acks only touch edge channels; a simultaneous rise wins.
    always_comb begin
        clr = '0;
        if (wr && paddr_i == REG_STATUS) clr = pwdata_i[NUM_IRQ-1:0];
        if (wr && paddr_i == REG_ID)     clr = ack;
        clr  = clr & ~mode;
        rise = enable_i ? (irq_trigger_i & ~prev & ~mode) : '0;
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev    <= '0;
            pending <= '0;
        end else begin
            if (enable_i) prev <= irq_trigger_i;
            pending <= (mode & (enable_i ? irq_trigger_i : pending))
                     | (~mode & ((pending & ~clr) | rise));
        end
    end

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mask <= '0;
            thr  <= '0;
            prio <= '0;
        end else begin
            if (wr && paddr_i == REG_MASK) mask <= pwdata_i[NUM_IRQ-1:0];
            if (wr && paddr_i == REG_THR)  thr  <= pwdata_i[PRIO_W-1:0];
            for (int k = 0; k < NUM_IRQ; k++)
                if (wr && prio_hit[k]) prio[k] <= pwdata_i[PRIO_W-1:0];
        end
    end

    for (genvar k = 0; k < NUM_IRQ; k++) begin : g_cand
        assign cand[k] = pending[k] & mask[k] & (prio[k] > thr);
    end

    irq_prio_arbiter #(.NUM_IRQ(NUM_IRQ), .PRIO_W(PRIO_W)) u_arb (
        .cand (cand),
        .prio (prio),
        .vld  (win_vld),
        .id   (win_id)
    );

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            interrupt_o <= 1'b0;
            irq_id_o    <= '0;
        end else if (enable_i) begin
            interrupt_o <= win_vld;
            if (win_vld) irq_id_o <= win_id;
        end
    end

    always_comb begin
        rdata = '0;
        case (paddr_i)
            REG_MODE:   rdata[NUM_IRQ-1:0] = mode;
            REG_ID: begin
                rdata[ID_VALID_BIT] = interrupt_o;
                rdata[ID_W-1:0]     = irq_id_o;
            end
            REG_STATUS: rdata[NUM_IRQ-1:0] = pending;
            REG_MASK:   rdata[NUM_IRQ-1:0] = mask;
            REG_THR:    rdata[PRIO_W-1:0]  = thr;
            default: begin
                for (int k = 0; k < NUM_IRQ; k++)
                    if (prio_hit[k]) rdata[PRIO_W-1:0] = prio[k];
            end
        endcase
    end

    assign prdata_o  = access ? rdata : '0;
    assign pslverr_o = access & ~mapped;

endmodule

// File: doc/apb_irq_controller_n.md
# apb_irq_controller_n

Parametrised APB interrupt controller, the next generation of the team's fixed 4-channel `interrupt_controller`. It takes `NUM_IRQ` synchronous request lines and holds per-channel pending, mask and priority state. A registered priority arbiter drives one interrupt line plus the winning channel ID to the CPU. Software programs it over a zero-wait-state APB slave. It adds per-channel level/edge mode, an ID/acknowledge register and error reporting on unmapped addresses.

## Interface
- `NUM_IRQ`, 8: number of request channels, 1..32.
- `PRIO_W`, 3: priority and threshold width, 1..8.
- `pclk_i` in 1: APB clock; the only clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `enable_i` in 1: core enable (clock-gating qualifier). Low freezes the core; APB still operates.
- `psel_i`, `penable_i`, `pwrite_i` in 1 each: APB control.
- `paddr_i` in 32: register index (word index, not byte address).
- `pwdata_i` in 32: write data. Bits above the used width are ignored.
- `prdata_o` out 32: read data, zero-extended.
- `pready_o` out 1: tied 1.
- `pslverr_o` out 1: high in the access phase to an unmapped index.
- `irq_trigger_i` in NUM_IRQ: request lines, synchronous to `pclk_i`.
- `interrupt_o` out 1: interrupt to the CPU.
- `irq_id_o` out ID_W: winning channel, where ID_W = max(1, clog2(NUM_IRQ)).

## Operation
- Register map:
  - 0 MODE: per channel, 1 = level, 0 = edge.
  - 1 ID: read gives bit31 = valid and bits[ID_W-1:0] = current ID. Write data k acknowledges channel k: clears pending[k] in edge mode, no effect in level mode. Reading has no side effect.
  - 2 STATUS: read gives pending. Write-1-to-clear, edge-mode channels only.
  - 3 MASK: 1 = channel enabled.
  - 4 THRESHOLD.
  - 5+k PRIO_k, for k = 0..NUM_IRQ-1.
  - Any other index: `pslverr_o`=1, reads 0, write ignored.
- APB writes commit at the rising edge with psel & penable & pwrite. `prdata_o` and `pslverr_o` are combinational in the access phase and 0 otherwise.
- Edge mode:
  - rise[k] = in[k] & ~prev[k]; prev resets to 0.
  - rise sets pending[k] at the same edge the input is sampled.
  - A line already high at reset release counts as a rising edge.
- Level mode: pending[k] is the registered input; clear and ack have no effect.
- Candidate[k] = pending[k] & mask[k] & (prio[k] > threshold).
  - Priority 0 can never interrupt.
  - Highest priority wins; a tie goes to the lowest index.
- `interrupt_o` = OR of the candidates, registered. `irq_id_o` = winner, registered, holds its last value when there is no candidate.
- Simultaneous set (edge) and clear/ack on one channel: set wins, pending stays 1.
- `enable_i`=0:
  - prev, pending, `interrupt_o` and `irq_id_o` hold.
  - APB register writes still commit.
  - Clears take effect on pending immediately.
  - Rise detection resumes against the frozen prev.
- Reset mid-operation: every register returns to 0 asynchronously; any APB transfer in flight is lost.

## Timing
- Reset values: all registers, pending and prev are 0. `interrupt_o`, `irq_id_o`, `prdata_o` and `pslverr_o` are 0. `pready_o` is 1.
- Request latency: input high before edge t gives pending after edge t, and `interrupt_o`/`irq_id_o` after edge t+1.
- Clear/ack latency: the access edge clears pending; `interrupt_o` drops, or `irq_id_o` moves to the next winner, after the following edge.
- A mask, priority or threshold write takes effect on the outputs one edge after the access edge.
- APB: two-cycle transfer (setup, access), no wait states.

## Configuration
- `IRQ_LEVEL_MODE_EN` defined: the MODE register and level-mode path exist.
- Not defined:
  - All channels are edge mode.
  - Index 0 reads 0; writes to it are ignored with `pslverr_o`=0.
  - No MODE flops are inferred.

## Structure
- Package `apb_irq_pkg` holds:
  - register index localparams (MODE, ID, STATUS, MASK, THR, PRIO_BASE);
  - the ID valid bit position;
  - a function for ID_W.
- Sub-module `irq_prio_arbiter` (combinational, parametrised by NUM_IRQ and PRIO_W):
  - inputs: candidate vector and flattened priorities;
  - outputs: any-valid flag and winner index.
  - Implemented as a lowest-index-first compare tree.
- All registers live in the top module.

## Test plan
All scenarios use NUM_IRQ=8, PRIO_W=3.
- Reset: read indices 0..12 -> all 0; `interrupt_o`=0; index 13 -> `pslverr_o`=1.
- Basic request:
  - Setup: THR=2, PRIO0=1, PRIO3=4, MASK=0x09.
  - Stimulus: 1-cycle pulse of 0x09.
  - Response: STATUS reads 0x09. Two edges after the pulse, `interrupt_o`=1 and `irq_id_o`=3. ID reads 0x80000003.
- Tie and acknowledge:
  - Setup: PRIO1=PRIO5=5, MASK=0x22.
  - Stimulus: pulse 0x22, then write ID=1.
  - Response: ID=1 before the acknowledge; ID=5 one edge after it.
- Threshold:
  - PRIO2=3, THR=3, MASK=0x04, pulse bit2 -> STATUS=0x04, `interrupt_o`=0.
  - Write THR=2 -> `interrupt_o`=1 one edge after the access edge.
- Level mode (macro defined):
  - Setup: MODE=0x10, MASK=0x10, PRIO4=7.
  - Hold input 4 high and write STATUS=0x10 -> bit stays 1.
  - Drop input 4 -> pending clears one edge later; `interrupt_o` falls the edge after.
- Collision and freeze:
  - Edge channel 0 with a pulse in the same cycle as a STATUS=0x01 write -> pending stays 1.
  - With `enable_i`=0, pulse 0x80 -> pending unchanged, `interrupt_o` held.
